// File: rtl/cache_2way_wb_ctrl_if.sv
// Bus bundle between the cache controller, the CPU port, the data array
// and main memory. The controller takes the slave view; the environment
// (CPU, array and memory models) takes the master view.
interface cache_2way_wb_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              cpu_hit;
    logic              arr_way;
    logic              arr_set;
    logic [1:0]        arr_word;
    logic              arr_word_we;
    logic              arr_fill_we;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, mem_ack,
        input  cpu_ready, cpu_hit, arr_way, arr_set, arr_word,
               arr_word_we, arr_fill_we, mem_req, mem_we, mem_addr
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, mem_ack,
        output cpu_ready, cpu_hit, arr_way, arr_set, arr_word,
               arr_word_we, arr_fill_we, mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/cache_2way_wb_ctrl.sv
// Hit/miss sequencer for a 2-way, 2-set write-back cache with 4-word blocks.
// Holds tag/valid/dirty/LRU state, steers the data-array strobes and runs
// dirty-victim write-back followed by block refill over a req/ack memory port.
module cache_2way_wb_ctrl #(
    parameter int ADDR_W = 10,
    parameter int TAG_W  = ADDR_W - 5
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_2way_wb_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic             req_set_q, req_set_d;
    logic [1:0]       req_word_q, req_word_d;
    logic             req_we_q, req_we_d;
    logic             miss_q, miss_d;
    logic             victim_q, victim_d;
    logic [1:0][1:0]  valid_q, valid_d;   // [way][set]
    logic [1:0][1:0]  dirty_q, dirty_d;   // [way][set]
    logic [1:0]       lru_q, lru_d;       // [set], names the way to evict next
    logic [TAG_W-1:0] tag_q [2][2];       // [way][set]
    logic             tag_we;
    logic             hit0, hit1, hit, hit_way, vict;
    logic             unused_ok;

    // Byte offset plays no role in a word/block-granular controller.
    assign unused_ok = ^bus.cpu_addr[1:0];

    // Lookup of the latched request: way0 wins on a hit; victim prefers an invalid way.
    always_comb begin
        hit0    = valid_q[0][req_set_q] && (tag_q[0][req_set_q] == req_tag_q);
        hit1    = valid_q[1][req_set_q] && (tag_q[1][req_set_q] == req_tag_q);
        hit     = hit0 || hit1;
        hit_way = !hit0;
        if (!valid_q[0][req_set_q]) begin
            vict = 1'b0;
        end else if (!valid_q[1][req_set_q]) begin
            vict = 1'b1;
        end else begin
            vict = lru_q[req_set_q];
        end
    end

    // Next-state, cache-state updates and all bus outputs.
    always_comb begin
        state_d         = state_q;
        req_tag_d       = req_tag_q;
        req_set_d       = req_set_q;
        req_word_d      = req_word_q;
        req_we_d        = req_we_q;
        miss_d          = miss_q;
        victim_d        = victim_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        lru_d           = lru_q;
        tag_we          = 1'b0;
        bus.cpu_ready   = 1'b0;
        bus.cpu_hit     = 1'b0;
        bus.arr_way     = 1'b0;
        bus.arr_set     = 1'b0;
        bus.arr_word    = 2'b00;
        bus.arr_word_we = 1'b0;
        bus.arr_fill_we = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    req_tag_d  = bus.cpu_addr[ADDR_W-1:5];
                    req_set_d  = bus.cpu_addr[4];
                    req_word_d = bus.cpu_addr[3:2];
                    req_we_d   = bus.cpu_we;
                    miss_d     = 1'b0;
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                bus.arr_set = req_set_q;
                if (hit) begin
                    bus.cpu_ready      = 1'b1;
                    bus.cpu_hit        = !miss_q;
                    bus.arr_way        = hit_way;
                    lru_d[req_set_q]   = !hit_way;
                    if (req_we_q) begin
                        bus.arr_word_we              = 1'b1;
                        bus.arr_word                 = req_word_q;
                        dirty_d[hit_way][req_set_q]  = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    miss_d   = 1'b1;
                    victim_d = vict;
                    state_d  = (valid_q[vict][req_set_q] && dirty_q[vict][req_set_q])
                               ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = {tag_q[victim_q][req_set_q], req_set_q, 4'b0000};
                bus.arr_way  = victim_q;
                bus.arr_set  = req_set_q;
                if (bus.mem_ack) begin
                    dirty_d[victim_q][req_set_q] = 1'b0;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {req_tag_q, req_set_q, 4'b0000};
                bus.arr_way  = victim_q;
                bus.arr_set  = req_set_q;
                if (bus.mem_ack) begin
                    bus.arr_fill_we              = 1'b1;
                    tag_we                       = 1'b1;
                    valid_d[victim_q][req_set_q] = 1'b1;
                    dirty_d[victim_q][req_set_q] = 1'b0;
                    state_d = COMPARE;
                end
            end
        endcase
    end

    // Control state; reset discards any in-flight request and invalidates the cache.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_tag_q  <= '0;
            req_set_q  <= 1'b0;
            req_word_q <= 2'b00;
            req_we_q   <= 1'b0;
            miss_q     <= 1'b0;
            victim_q   <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_tag_q  <= req_tag_d;
            req_set_q  <= req_set_d;
            req_word_q <= req_word_d;
            req_we_q   <= req_we_d;
            miss_q     <= miss_d;
            victim_q   <= victim_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lru_q      <= lru_d;
        end
    end

    // Tag store; contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[victim_q][req_set_q] <= req_tag_q;
        end
    end
endmodule

// File: tb/tb_cache_2way_wb_ctrl.sv
// Bench for the 2-way write-back cache controller: directed table of
// requests, randomized requests against a set/way reference model, and a
// reset-during-refill sequence.
module tb_cache_2way_wb_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_2way_wb_ctrl_if #(.ADDR_W(10)) cif();

    cache_2way_wb_ctrl #(.ADDR_W(10), .TAG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cif)
    );

    typedef struct {
        logic       timeout;
        logic       hit;
        int         way;
        int         nwb;
        logic [9:0] wb_addr;
        int         nal;
        logic [9:0] al_addr;
        int         fill;
        int         lat;
        logic       wordok;
    } res_t;

    typedef struct {
        logic       we;
        logic [9:0] addr;
        int         dly;
        logic       hit;
        int         way;
        int         nwb;
        logic [9:0] wb_addr;
        logic [9:0] al_addr;
        int         lat;
    } vec_t;

    // Reference cache contents: [way][set]
    logic       m_valid [2][2];
    logic       m_dirty [2][2];
    logic [4:0] m_tag   [2][2];
    logic       m_lru   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 2; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_tag[w][s]   = '0;
            end
            m_lru[w] = 1'b0;
        end
    endtask

    // Expected outcome of one request from the cache's architectural rules.
    task automatic model_req(input logic we, input logic [9:0] a, input int dly, output res_t e);
        int s, hw, vw;
        logic [4:0] t;
        logic wb;
        s = int'(a[4]);
        t = a[9:5];
        hw = -1;
        e = '{timeout: 1'b0, hit: 1'b0, way: 0, nwb: 0, wb_addr: '0, nal: 0,
              al_addr: '0, fill: -1, lat: 1, wordok: 1'b1};
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_valid[w][s] && m_tag[w][s] == t) hw = w;
        if (hw >= 0) begin
            e.hit = 1'b1;
            e.way = hw;
        end else begin
            vw = -1;
            for (int w = 0; w < 2; w++)
                if (vw < 0 && !m_valid[w][s]) vw = w;
            if (vw < 0) vw = int'(m_lru[s]);
            wb = m_valid[vw][s] && m_dirty[vw][s];
            if (wb) begin
                e.nwb     = 1;
                e.wb_addr = {m_tag[vw][s], a[4], 4'b0000};
            end
            e.nal     = 1;
            e.al_addr = {t, a[4], 4'b0000};
            e.fill    = vw;
            e.way     = vw;
            e.lat     = 3 + dly + (wb ? dly + 1 : 0);
            m_valid[vw][s] = 1'b1;
            m_dirty[vw][s] = 1'b0;
            m_tag[vw][s]   = t;
        end
        m_lru[s] = (e.way == 0);
        if (we) m_dirty[e.way][s] = 1'b1;
    endtask

    // Issues one request from IDLE and plays memory with a fixed ack delay.
    task automatic run_req(input logic we, input logic [9:0] addr, input int dly, output res_t g);
        int cyc, wcnt;
        logic done, ack;
        g = '{timeout: 1'b0, hit: 1'b0, way: -1, nwb: 0, wb_addr: '0, nal: 0,
              al_addr: '0, fill: -1, lat: -1, wordok: 1'b0};
        @(negedge clk);
        chk("idle_outputs", {cif.cpu_ready, cif.mem_req, cif.arr_word_we, cif.arr_fill_we}, 4'b0000);
        cif.cpu_req  = 1'b1;
        cif.cpu_we   = we;
        cif.cpu_addr = addr;
        cyc = 0; wcnt = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            cif.cpu_req  = 1'b0;
            cif.cpu_we   = 1'($urandom_range(0, 1));
            cif.cpu_addr = 10'($urandom_range(0, 1023));
            ack = 1'b0;
            if (cif.mem_req) begin
                if (wcnt == dly) begin
                    ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            cif.mem_ack = ack;
            #1;
            if (ack) begin
                if (cif.mem_we) begin
                    g.nwb++;
                    g.wb_addr = cif.mem_addr;
                end else begin
                    g.nal++;
                    g.al_addr = cif.mem_addr;
                    g.fill    = cif.arr_fill_we ? int'(cif.arr_way) : -2;
                end
            end
            if (cif.cpu_ready) begin
                done     = 1'b1;
                g.hit    = cif.cpu_hit;
                g.way    = int'(cif.arr_way);
                g.lat    = cyc;
                g.wordok = (cif.arr_word_we == we) && (cif.arr_set == addr[4]) &&
                           (!we || cif.arr_word == addr[3:2]);
            end
        end
        cif.mem_ack = 1'b0;
        g.timeout = !done;
    endtask

    task automatic cmp_res(input string n, input res_t g, input res_t e);
        chk({n, ".timeout"}, 32'(g.timeout), 32'd0);
        if (!g.timeout) begin
            chk({n, ".hit"}, 32'(g.hit), 32'(e.hit));
            chk({n, ".way"}, g.way, e.way);
            chk({n, ".nwb"}, g.nwb, e.nwb);
            chk({n, ".nal"}, g.nal, e.nal);
            chk({n, ".fill_way"}, g.fill, e.fill);
            chk({n, ".latency"}, g.lat, e.lat);
            chk({n, ".word_strobe"}, 32'(g.wordok), 32'd1);
            if (e.nwb > 0) chk({n, ".wb_addr"}, 32'(g.wb_addr), 32'(e.wb_addr));
            if (e.nal > 0) chk({n, ".alloc_addr"}, 32'(g.al_addr), 32'(e.al_addr));
        end
    endtask

    vec_t       vt [11];
    logic [4:0] tpool [4];
    res_t       g, e;
    int         n, seen;
    logic [9:0] ra;
    logic       rwe;
    int         rd;

    initial begin
        // we, addr, dly, hit, way, nwb, wb_addr, al_addr, lat
        vt[0]  = '{1'b0, 10'h000, 2, 1'b0, 0, 0, 10'h000, 10'h000, 5};
        vt[1]  = '{1'b1, 10'h000, 0, 1'b1, 0, 0, 10'h000, 10'h000, 1};
        vt[2]  = '{1'b0, 10'h200, 1, 1'b0, 1, 0, 10'h000, 10'h200, 4};
        vt[3]  = '{1'b0, 10'h000, 0, 1'b1, 0, 0, 10'h000, 10'h000, 1};
        vt[4]  = '{1'b0, 10'h300, 0, 1'b0, 1, 0, 10'h000, 10'h300, 3};
        vt[5]  = '{1'b0, 10'h200, 1, 1'b0, 0, 1, 10'h000, 10'h200, 6};
        vt[6]  = '{1'b1, 10'h01C, 0, 1'b0, 0, 0, 10'h000, 10'h010, 3};
        vt[7]  = '{1'b0, 10'h018, 0, 1'b1, 0, 0, 10'h000, 10'h000, 1};
        vt[8]  = '{1'b1, 10'h034, 0, 1'b0, 1, 0, 10'h000, 10'h030, 3};
        vt[9]  = '{1'b0, 10'h210, 2, 1'b0, 0, 1, 10'h010, 10'h210, 8};
        vt[10] = '{1'b0, 10'h030, 0, 1'b1, 1, 0, 10'h000, 10'h000, 1};
        tpool[0] = 5'h00; tpool[1] = 5'h01; tpool[2] = 5'h10; tpool[3] = 5'h18;

        cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = '0; cif.mem_ack = 1'b0;
        model_reset();

        // Outputs held quiet while reset is asserted.
        @(negedge clk); @(negedge clk);
        chk("reset.cpu_ready", 32'(cif.cpu_ready), 32'd0);
        chk("reset.mem_req", 32'(cif.mem_req), 32'd0);
        chk("reset.strobes", {cif.arr_word_we, cif.arr_fill_we, cif.mem_we}, 3'b000);
        chk("reset.mem_addr", 32'(cif.mem_addr), 32'd0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            e = '{timeout: 1'b0, hit: vt[i].hit, way: vt[i].way, nwb: vt[i].nwb,
                  wb_addr: vt[i].wb_addr, nal: vt[i].hit ? 0 : 1, al_addr: vt[i].al_addr,
                  fill: vt[i].hit ? -1 : vt[i].way, lat: vt[i].lat, wordok: 1'b1};
            begin
                res_t dummy;
                model_req(vt[i].we, vt[i].addr, vt[i].dly, dummy);
            end
            run_req(vt[i].we, vt[i].addr, vt[i].dly, g);
            cmp_res($sformatf("vec%0d", i), g, e);
        end

        // Randomized requests against the reference model
        for (int i = 0; i < 80; i++) begin
            ra  = {tpool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            rwe = 1'($urandom_range(0, 1));
            rd  = int'($urandom_range(0, 3));
            model_req(rwe, ra, rd, e);
            run_req(rwe, ra, rd, g);
            cmp_res($sformatf("rnd%0d", i), g, e);
        end

        // Reset while a refill is outstanding and memory is slow to answer.
        @(negedge clk);
        cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 10'h3E0;
        @(negedge clk);
        cif.cpu_req = 1'b0;
        n = 0; seen = 0;
        while (n < 30 && seen < 3) begin
            @(negedge clk);
            n++;
            cif.mem_ack = cif.mem_req && cif.mem_we;
            if (cif.mem_req && !cif.mem_we) seen++;
        end
        cif.mem_ack = 1'b0;
        chk("rst_mid.in_allocate", seen, 3);
        reset = 1'b1;
        #1;
        chk("rst_mid.mem_req_drop", 32'(cif.mem_req), 32'd0);
        chk("rst_mid.quiet", {cif.cpu_ready, cif.arr_fill_we, cif.mem_we}, 3'b000);
        @(negedge clk);
        chk("rst_mid.mem_req_held", 32'(cif.mem_req), 32'd0);
        reset = 1'b0;
        model_reset();
        model_req(1'b0, 10'h000, 1, e);
        run_req(1'b0, 10'h000, 1, g);
        cmp_res("post_rst0", g, e);
        chk("post_rst0.miss", 32'(g.hit), 32'd0);
        model_req(1'b0, 10'h3E0, 0, e);
        run_req(1'b0, 10'h3E0, 0, g);
        cmp_res("post_rst1", g, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_2way_wb_ctrl.md
Name: cache_2way_wb_ctrl

Overview:
Miss/hit sequencing controller for the 2-way set-associative write-back cache: 10-bit byte address, 4-word (128-bit) blocks, 2 sets, LRU replacement. It holds the tag, valid, dirty and LRU state and accepts one CPU request at a time. It drives the data-array write strobes and runs dirty-victim write-back and block refill through a req/ack memory handshake. It sits between the CPU port and the cache data array / main memory.

Parameters:
ADDR_W, 10, byte address width
TAG_W, 5, tag width (ADDR_W-5); address split tag[9:5], set[4], word[3:2], byte[1:0]

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
cpu_req  in  1  request valid; sampled only in IDLE
cpu_we  in  1  1=write word, 0=read block
cpu_addr  in  10  request byte address
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  valid with cpu_ready; 1 = request hit on first lookup
arr_way  out  1  data-array way select
arr_set  out  1  data-array set select
arr_word  out  2  word select for CPU write
arr_word_we  out  1  write cpu write_data into the selected word
arr_fill_we  out  1  write the 128-bit memory block into the selected way/set
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1=write-back victim block, 0=block read
mem_addr  out  10  block-aligned address, bits [3:0]=0
mem_ack  in  1  one-cycle completion; ignored when mem_req=0

Behaviour:
- Reset (async): state IDLE. All valid, dirty and LRU bits = 0. All outputs 0.
- Reset mid-miss: mem_req drops at once. The latched request is discarded.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: if cpu_req=1, latch addr/we, clear miss_flag, go to COMPARE next cycle.
- COMPARE: hit = valid[way][set] && tag[way][set]==latched tag; way0 is checked first.
  - On hit: cpu_ready=1 and cpu_hit=!miss_flag (combinational in this cycle); arr_way=hit way; arr_set=set; LRU[set] = ~hit way; go to IDLE.
  - Write hit: also arr_word_we=1 with arr_word=addr[3:2], and dirty[way][set]=1.
  - On miss: set miss_flag. Victim = the first invalid way (way0 before way1), else LRU[set].
  - Victim valid and dirty: go to WRITEBACK. Otherwise: go to ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, set, 4'b0000}, arr_way=victim.
  - Hold until mem_ack. On ack: dirty[victim][set]=0, go to ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr={latched tag, set, 4'b0000}.
  - On mem_ack, in the same cycle: arr_fill_we=1, arr_way=victim; tag=latched tag, valid=1, dirty=0; go to COMPARE.
  - The re-lookup then hits: cpu_hit=0 and the LRU is updated.
- Latency:
  - Hit: cpu_ready 1 cycle after the IDLE accept.
  - Clean miss: accept + compare + allocate wait + compare.
  - Dirty miss: adds the write-back wait.
- Outputs in IDLE: cpu_ready=0, mem_req=0, all strobes 0.
- cpu_req/cpu_addr changes after accept are ignored until the next IDLE.
- mem_ack arriving in the same cycle mem_req first rises is accepted.
- A back-to-back request is accepted in the IDLE cycle after cpu_ready.

Test Plan:
- Reset, then read 0x000 -> ALLOCATE with mem_addr=0x000, mem_we=0. On ack: arr_fill_we=1, arr_way=0. Next cycle cpu_ready=1, cpu_hit=0. LRU[0]=1.
- Write 0x000 -> cpu_ready one cycle after accept, cpu_hit=1, arr_word_we=1, arr_word=0. dirty[0][0]=1. No mem_req.
- Read 0x200 -> miss; fill goes to way1 (way1 invalid), no write-back. Ends cpu_hit=0, LRU[0]=0.
- Read 0x000 -> hit in way0, cpu_hit=1, LRU[0]=1.
- Read 0x300 -> miss; victim is way1 (0x200, clean), so ALLOCATE only, mem_addr=0x300. LRU[0]=0.
- Read 0x200 -> miss; victim is way0 (dirty 0x000). WRITEBACK with mem_we=1, mem_addr=0x000, then ALLOCATE with mem_addr=0x200. cpu_hit=0.
- Assert reset during ALLOCATE with mem_ack delayed 5 cycles -> mem_req=0 immediately, all valid bits cleared, next read misses.
